// File: rtl/memory_controller.sv
`default_nettype none
// ============================================================================
// Module      : memory_controller
// Description : Shares one byte-wide RAM/IO port between the instruction and
//               data requesters, serialising word/half/byte accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_controller #(
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        flush_signal,
    input  logic        i_req_en,
    input  logic [31:0] i_addr,
    output logic        i_data_en,
    output logic [31:0] i_data,
    output logic [31:0] i_addr_confirm,
    input  logic        d_req_en,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] IREAD   = 2'd1;
    localparam logic [1:0] DREAD   = 2'd2;
    localparam logic [1:0] DWRITE  = 2'd3;
    localparam logic       GRANT_I = 1'b0;
    localparam logic       GRANT_D = 1'b1;

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic        last_q, last_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        i_en_q, i_en_d;
    logic [31:0] i_data_q, i_data_d;
    logic [31:0] i_conf_q, i_conf_d;
    logic        d_done_q, d_done_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        w_take_dside;
    logic        w_take_iside;
    logic        w_rd_last;
    logic [2:0]  w_wr_nxt;
    logic        w_io_stall;
    logic        w_grant_stall;
    logic [31:0] w_merged;
    logic [7:0]  w_wbyte;

    // On contention the side that did not win last time goes next.
    assign w_take_dside  = d_req_en && (!i_req_en || (last_q == GRANT_I));
    assign w_take_iside  = i_req_en && !w_take_dside;
    assign w_rd_last     = (cnt_q + 3'd1) == size_q;
    // A write byte is consumed only on an edge where mem_wr was actually high.
    assign w_wr_nxt      = mem_wr_q ? (cnt_q + 3'd1) : cnt_q;
    assign w_io_stall    = io_buffer_full && (addr_q[17:16] == IO_SEL);
    assign w_grant_stall = io_buffer_full && (d_addr[17:16] == IO_SEL);

    always_comb begin
        w_merged = buf_q;
        case (cnt_q[1:0])
            2'd0:    w_merged[7:0]   = mem_din;
            2'd1:    w_merged[15:8]  = mem_din;
            2'd2:    w_merged[23:16] = mem_din;
            default: w_merged[31:24] = mem_din;
        endcase
    end

    always_comb begin
        case (w_wr_nxt[1:0])
            2'd0:    w_wbyte = wdata_q[7:0];
            2'd1:    w_wbyte = wdata_q[15:8];
            2'd2:    w_wbyte = wdata_q[23:16];
            default: w_wbyte = wdata_q[31:24];
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            size_q     <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            buf_q      <= 32'd0;
            last_q     <= GRANT_I;
            mem_a_q    <= 32'd0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            i_en_q     <= 1'b0;
            i_data_q   <= 32'd0;
            i_conf_q   <= 32'd0;
            d_done_q   <= 1'b0;
            d_rdata_q  <= 32'd0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            last_q     <= last_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            i_en_q     <= i_en_d;
            i_data_q   <= i_data_d;
            i_conf_q   <= i_conf_d;
            d_done_q   <= d_done_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!flush_signal) begin
                    if (w_take_dside)      state_d = d_wr ? DWRITE : DREAD;
                    else if (w_take_iside) state_d = IREAD;
                end
            end
            IREAD, DREAD: if (flush_signal || w_rd_last) state_d = IDLE;
            DWRITE:       if (w_wr_nxt == size_q) state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        last_d     = last_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = 1'b0;
        i_en_d     = 1'b0;
        i_data_d   = i_data_q;
        i_conf_d   = i_conf_q;
        d_done_d   = 1'b0;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (!flush_signal && w_take_dside) begin
                    addr_d  = d_addr;
                    size_d  = (d_size == 2'b00) ? 3'd1 : ((d_size == 2'b01) ? 3'd2 : 3'd4);
                    wdata_d = d_wdata;
                    buf_d   = 32'd0;
                    cnt_d   = 3'd0;
                    mem_a_d = d_addr;
                    last_d  = GRANT_D;
                    if (d_wr && !w_grant_stall) begin
                        mem_dout_d = d_wdata[7:0];
                        mem_wr_d   = 1'b1;
                    end
                end else if (!flush_signal && w_take_iside) begin
                    addr_d  = i_addr;
                    size_d  = 3'd4;
                    buf_d   = 32'd0;
                    cnt_d   = 3'd0;
                    mem_a_d = i_addr;
                    last_d  = GRANT_I;
                end
            end
            IREAD, DREAD: begin
                if (!flush_signal) begin
                    buf_d = w_merged;
                    cnt_d = cnt_q + 3'd1;
                    if (!w_rd_last) begin
                        mem_a_d = addr_q + {29'd0, cnt_q + 3'd1};
                    end else if (state_q == IREAD) begin
                        i_en_d   = 1'b1;
                        i_data_d = w_merged;
                        i_conf_d = addr_q;
                    end else begin
                        d_done_d  = 1'b1;
                        d_rdata_d = w_merged;
                    end
                end
            end
            DWRITE: begin
                cnt_d = w_wr_nxt;
                if (w_wr_nxt == size_q) begin
                    d_done_d = 1'b1;
                end else if (!w_io_stall) begin
                    mem_a_d    = addr_q + {29'd0, w_wr_nxt};
                    mem_dout_d = w_wbyte;
                    mem_wr_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign mem_a          = mem_a_q;
    assign mem_dout       = mem_dout_q;
    assign mem_wr         = mem_wr_q;
    assign i_data_en      = i_en_q;
    assign i_data         = i_data_q;
    assign i_addr_confirm = i_conf_q;
    assign d_done         = d_done_q;
    assign d_rdata        = d_rdata_q;

endmodule
`default_nettype wire
